sram_access_ctrl: RTL and testbench

//  Timing sequencer between the CPU memory port and the external 1Mx16 async SRAM.

---
 rtl/sram_access_ctrl_if.sv | 25 ++
 rtl/sram_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_sram_access_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// CPU-side request/response port of the SRAM access controller.
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        byte_en;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output req, wr, addr, wdata, byte_en,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, wr, addr, wdata, byte_en,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences single-cycle CPU read/write requests into async SRAM strobe cycles
// with programmable wait states and a post-access bus turnaround.
module sram_access_ctrl #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_ctrl_if.slave cpu,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] Data,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB
);

    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT)
                                     ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                     : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? (TURN - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_DONE,
        S_TURN
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         be_q;
    logic [1:0]         lanes_sel;
    logic [DATA_W-1:0]  dout;
    logic [DATA_W-1:0]  rdata_q;
    logic               data_oe;
    logic               ack_q, busy_q, err_q;
    logic               accept;
    logic               ce_nxt, oe_nxt, we_nxt, ub_nxt, lb_nxt, drv_nxt;

    assign accept    = (state == S_IDLE) && cpu.req;
    // Lane selects must be valid in the first access cycle, before be_q loads.
    assign lanes_sel = (state == S_IDLE) ? cpu.byte_en : be_q;

    // Next-state and next-strobe decode; strobes are registered from state_nxt.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        ce_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        we_nxt    = 1'b1;
        ub_nxt    = 1'b1;
        lb_nxt    = 1'b1;
        drv_nxt   = 1'b0;

        case (state)
            S_IDLE:   if (cpu.req) state_nxt = cpu.wr ? S_WSETUP : S_READ;
            S_READ:   if (cnt == RD_LAST) state_nxt = S_DONE;
                      else cnt_nxt = cnt + CNT_W'(1);
            S_WSETUP: state_nxt = S_WPULSE;
            S_WPULSE: if (cnt == WR_LAST) state_nxt = S_WHOLD;
                      else cnt_nxt = cnt + CNT_W'(1);
            S_WHOLD:  state_nxt = S_DONE;
            S_DONE:   state_nxt = (TURN > 0) ? S_TURN : S_IDLE;
            S_TURN:   if (cnt == TURN_LAST) state_nxt = S_IDLE;
                      else cnt_nxt = cnt + CNT_W'(1);
            default:  state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_READ: begin
                ce_nxt = 1'b0;
                oe_nxt = 1'b0;
                ub_nxt = ~lanes_sel[1];
                lb_nxt = ~lanes_sel[0];
            end
            S_WSETUP, S_WPULSE, S_WHOLD: begin
                ce_nxt  = 1'b0;
                we_nxt  = (state_nxt != S_WPULSE);
                ub_nxt  = ~lanes_sel[1];
                lb_nxt  = ~lanes_sel[0];
                drv_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State, strobes, latched request and CPU-side status.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            CE      <= 1'b1;
            OE      <= 1'b1;
            WE      <= 1'b1;
            UB      <= 1'b1;
            LB      <= 1'b1;
            data_oe <= 1'b0;
            A       <= '0;
            dout    <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            CE      <= ce_nxt;
            OE      <= oe_nxt;
            WE      <= we_nxt;
            UB      <= ub_nxt;
            LB      <= lb_nxt;
            data_oe <= drv_nxt;
            ack_q   <= (state_nxt == S_DONE);
            busy_q  <= (state_nxt != S_IDLE);
            err_q   <= err_q | (cpu.req & busy_q);
            if (accept) begin
                A    <= cpu.addr;
                dout <= cpu.wdata;
                be_q <= cpu.byte_en;
            end
            if (state == S_READ && cnt == RD_LAST) rdata_q <= Data;
        end
    end

    assign Data      = data_oe ? dout : {DATA_W{1'bz}};
    assign cpu.rdata = rdata_q;
    assign cpu.ack   = ack_q;
    assign cpu.busy  = busy_q;
    assign cpu.err   = err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural async SRAM and a
// scoreboard of expected ack latency / read data.
module tb_sram_access_ctrl;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          Clk   = 1'b0;
    logic          Reset = 1'b0;
    logic [AW-1:0] A;
    tri1  [DW-1:0] Data;
    logic          CE, OE, WE, UB, LB;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          is_rd;
        int            lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int acks;
        int ce_lo;
        int oe_lo;
        int we_lo;
        int ub_lo;
        int lb_lo;
        int a_bad;
        int d_bad;
        int z_bad;
        int conflict;
    } stat_t;

    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) cpu ();

    sram_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(2), .WR_WAIT(2), .TURN(1)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .cpu  (cpu.slave),
        .A    (A),
        .Data (Data),
        .CE   (CE),
        .OE   (OE),
        .WE   (WE),
        .UB   (UB),
        .LB   (LB)
    );

    always #5 Clk = ~Clk;

    // Async SRAM: drives on CE&OE, writes selected lanes on the WE rising edge.
    assign Data = (!CE && !OE) ? mem[A] : 'z;
    always @(posedge WE) begin
        if (!CE) begin
            if (!LB) mem[A][7:0]  = Data[7:0];
            if (!UB) mem[A][15:8] = Data[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input logic [1:0] be, input int lat, input logic [DW-1:0] er);
        exp_t e;
        @(negedge Clk);
        cpu.req     = 1'b1;
        cpu.wr      = w;
        cpu.addr    = ad;
        cpu.wdata   = wd;
        cpu.byte_en = be;
        e.rdata = er;
        e.is_rd = !w;
        e.lat   = lat;
        sb.push_back(e);
        @(negedge Clk);
        cpu.req = 1'b0;
    endtask

    // Samples cycles first..last after the accept edge; pops the scoreboard on ack.
    task automatic watch(input int first, input int last, input logic [AW-1:0] ea,
                         input logic [DW-1:0] ed, output stat_t s);
        exp_t e;
        s = '{default: 0};
        for (int k = first; k <= last; k++) begin
            if (cpu.ack === 1'b1) begin
                s.acks++;
                chk("ack_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ack_latency", k, e.lat);
                    if (e.is_rd) chk("rdata", 32'(cpu.rdata), 32'(e.rdata));
                end
            end
            if (!CE) s.ce_lo++;
            if (!OE) s.oe_lo++;
            if (!WE) s.we_lo++;
            if (!UB) s.ub_lo++;
            if (!LB) s.lb_lo++;
            if (!CE && A !== ea) s.a_bad++;
            if (!CE && OE && Data !== ed) s.d_bad++;
            if (CE && Data !== 16'hFFFF) s.z_bad++;
            if (!OE && (!WE || Data !== mem[A])) s.conflict++;
            if (k < last) @(negedge Clk);
        end
    endtask

    initial begin
        stat_t s;
        int    n_ack;

        cpu.req = 1'b0; cpu.wr = 1'b0; cpu.addr = '0; cpu.wdata = '0; cpu.byte_en = '0;
        mem[20'h12345] = 16'hBEEF;
        mem[20'h00010] = 16'h1122;
        mem[20'h00200] = 16'h0F0F;
        mem[20'h00201] = 16'h0000;
        mem[20'h00300] = 16'h4242;
        mem[20'h00040] = 16'h0000;
        mem[20'h0FFFF] = 16'h1357;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_strobes", 32'({CE, OE, WE, UB, LB}), 32'h1F);
        chk("rst_addr", 32'(A), 32'h0);
        chk("rst_data_z", 32'(Data), 32'hFFFF);
        chk("rst_rdata", 32'(cpu.rdata), 32'h0);
        chk("rst_ack_busy_err", 32'({cpu.ack, cpu.busy, cpu.err}), 32'h0);
        Reset = 1'b1;

        // 1: read 0x12345
        issue(1'b0, 20'h12345, 16'h0000, 2'b11, 3, 16'hBEEF);
        watch(1, 4, 20'h12345, 16'h0000, s);
        chk("t1_acks", s.acks, 1);
        chk("t1_oe_cycles", s.oe_lo, 2);
        chk("t1_ce_cycles", s.ce_lo, 2);
        chk("t1_we_cycles", s.we_lo, 0);
        chk("t1_lane_cycles", s.ub_lo + s.lb_lo, 4);
        chk("t1_addr_bad", s.a_bad, 0);
        chk("t1_data_z_bad", s.z_bad, 0);
        chk("t1_addr_hold", 32'(A), 32'h12345);

        // 2: lower-lane write 0xA5A5 to 0x00010
        issue(1'b1, 20'h00010, 16'hA5A5, 2'b01, 5, 16'h0000);
        watch(1, 6, 20'h00010, 16'hA5A5, s);
        chk("t2_acks", s.acks, 1);
        chk("t2_we_cycles", s.we_lo, 2);
        chk("t2_lb_cycles", s.lb_lo, 4);
        chk("t2_ub_cycles", s.ub_lo, 0);
        chk("t2_ce_cycles", s.ce_lo, 4);
        chk("t2_oe_cycles", s.oe_lo, 0);
        chk("t2_data_bad", s.d_bad, 0);
        chk("t2_addr_bad", s.a_bad, 0);
        chk("t2_mem", 32'(mem[20'h00010]), 32'h11A5);
        chk("t2_rdata_kept", 32'(cpu.rdata), 32'hBEEF);

        // 3: read then write at the earliest legal accept
        issue(1'b0, 20'h00200, 16'h0000, 2'b11, 3, 16'h0F0F);
        watch(1, 4, 20'h00200, 16'h0000, s);
        chk("t3_turn_strobes", 32'({CE, OE, WE}), 32'h7);
        chk("t3_turn_data_z", 32'(Data), 32'hFFFF);
        chk("t3_turn_busy", 32'(cpu.busy), 32'h1);
        chk("t3_rd_conflict", s.conflict, 0);
        chk("t3_rd_z_bad", s.z_bad, 0);
        issue(1'b1, 20'h00201, 16'h3C3C, 2'b11, 5, 16'h0000);
        watch(1, 6, 20'h00201, 16'h3C3C, s);
        chk("t3_wr_conflict", s.conflict, 0);
        chk("t3_wr_data_bad", s.d_bad, 0);
        chk("t3_wr_z_bad", s.z_bad, 0);
        chk("t3_no_err", 32'(cpu.err), 32'h0);
        chk("t3_mem", 32'(mem[20'h00201]), 32'h3C3C);

        // 4: request during READ is dropped and flagged
        issue(1'b0, 20'h00300, 16'h0000, 2'b11, 3, 16'h4242);
        cpu.req = 1'b1; cpu.wr = 1'b1; cpu.addr = 20'h00999; cpu.wdata = 16'h7777;
        @(negedge Clk);
        cpu.req = 1'b0;
        watch(2, 6, 20'h00300, 16'h0000, s);
        chk("t4_acks", s.acks, 1);
        chk("t4_addr_bad", s.a_bad, 0);
        chk("t4_err", 32'(cpu.err), 32'h1);
        chk("t4_addr_hold", 32'(A), 32'h00300);
        chk("t4_sb_empty", sb.size(), 0);

        // 5: reset during WPULSE
        issue(1'b1, 20'h00040, 16'h6789, 2'b11, 5, 16'h0000);
        watch(1, 2, 20'h00040, 16'h6789, s);
        chk("t5_in_pulse", s.we_lo, 1);
        #1 Reset = 1'b0;
        #1;
        chk("t5_strobes_async", 32'({CE, OE, WE, UB, LB}), 32'h1F);
        chk("t5_data_z", 32'(Data), 32'hFFFF);
        n_ack = 0;
        repeat (3) begin
            @(negedge Clk);
            if (cpu.ack !== 1'b0) n_ack++;
        end
        chk("t5_no_ack", n_ack, 0);
        chk("t5_aborted_pending", sb.size(), 1);
        sb.delete();
        Reset = 1'b1;
        chk("t5_err_cleared", 32'({cpu.err, cpu.busy}), 32'h0);
        issue(1'b0, 20'h12345, 16'h0000, 2'b11, 3, 16'hBEEF);
        watch(1, 4, 20'h12345, 16'h0000, s);
        chk("t5_post_acks", s.acks, 1);

        // 6: byte_en=00 write still sequences but touches no lane
        issue(1'b1, 20'h0FFFF, 16'hDEAD, 2'b00, 5, 16'h0000);
        watch(1, 6, 20'h0FFFF, 16'hDEAD, s);
        chk("t6_acks", s.acks, 1);
        chk("t6_lanes", s.ub_lo + s.lb_lo, 0);
        chk("t6_we_cycles", s.we_lo, 2);
        chk("t6_mem", 32'(mem[20'h0FFFF]), 32'h1357);

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
